param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, registered occupancy flags
// and sticky overflow/underflow error flags.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                          Clk,
    input  logic                          Clr_bar,
    input  logic                          Wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          Rd_en,
    input  logic                          Err_clr,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          Empty,
    output logic                          Full,
    output logic                          Almost_full,
    output logic                          Almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overflow,
    output logic                          Underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [CW-1:0]         w_count_next;

    // A full FIFO is never empty, so a simultaneous read always frees a slot.
    always_comb begin
        w_rd_acc     = Rd_en & ~r_empty;
        w_wr_acc     = Wr_en & (~r_full | w_rd_acc);
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (Clr_bar && w_wr_acc) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr_bar) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + AW'(1);
                r_dout <= r_mem[r_rptr];
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == DEPTH_C);
            r_af    <= (w_count_next >= AF_C);
            r_ae    <= (w_count_next <= AE_C);
            // A new error in the same cycle as Err_clr wins.
            r_ovf   <= (Wr_en & ~w_wr_acc) | (r_ovf & ~Err_clr);
            r_unf   <= (Rd_en & r_empty) | (r_unf & ~Err_clr);
        end
    end

    assign data_out     = r_dout;
    assign Empty        = r_empty;
    assign Full         = r_full;
    assign Almost_full  = r_af;
    assign Almost_empty = r_ae;
    assign Count        = r_count;
    assign Overflow     = r_ovf;
    assign Underflow    = r_unf;

endmodule
